// File: rtl/light_track_if.sv
// Button and display bundle between the synchronised
// player inputs, the light_track controller and the LED driver.
interface light_track_if #(
    parameter int NUM_LIGHTS = 9,
    parameter int SCORE_W    = 3
);
    logic                  L;
    logic                  R;
    logic [NUM_LIGHTS-1:0] lights;
    logic [1:0]            winner;
    logic [SCORE_W-1:0]    score_l;
    logic [SCORE_W-1:0]    score_r;
    logic                  game_over;

    modport master (
        output L, R,
        input  lights, winner, score_l, score_r, game_over
    );

    modport slave (
        input  L, R,
        output lights, winner, score_l, score_r, game_over
    );
endinterface

// File: rtl/light_track.sv
// Centralised tug-of-war light row: one lit position pushed by
// edge-detected L/R presses, per-side scores and a timed win display.
module light_track #(
    parameter int NUM_LIGHTS  = 9,
    parameter int HOLD_CYCLES = 8,
    parameter int SCORE_W     = 3
) (
    input  logic         Clock,
    input  logic         Reset,
    light_track_if.slave io_bus
);
    localparam int PW = (NUM_LIGHTS > 1) ? $clog2(NUM_LIGHTS) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [PW-1:0]      P_CTR  = PW'((NUM_LIGHTS - 1) / 2);
    localparam logic [PW-1:0]      P_MAX  = PW'(NUM_LIGHTS - 1);
    localparam logic [HW-1:0]      H_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [SCORE_W-1:0] S_MAX  = '1;
    localparam logic [NUM_LIGHTS-1:0] ONE = NUM_LIGHTS'(1);

    typedef enum logic [1:0] {
        S_PLAY = 2'b00,
        S_WIN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t                r_state;
    logic [PW-1:0]         r_pos;
    logic [HW-1:0]         r_hold;
    logic                  r_prev_l;
    logic                  r_prev_r;
    logic [NUM_LIGHTS-1:0] r_lights;
    logic [1:0]            r_winner;
    logic [SCORE_W-1:0]    r_score_l;
    logic [SCORE_W-1:0]    r_score_r;
    logic                  r_game_over;

    state_t                w_state;
    logic [PW-1:0]         w_pos;
    logic [HW-1:0]         w_hold;
    logic [NUM_LIGHTS-1:0] w_lights;
    logic [1:0]            w_winner;
    logic [SCORE_W-1:0]    w_score_l;
    logic [SCORE_W-1:0]    w_score_r;
    logic                  w_game_over;
    logic                  w_press_l;
    logic                  w_press_r;
    logic                  w_move_l;
    logic                  w_move_r;

    function automatic logic [SCORE_W-1:0] sat_inc(
        input logic [SCORE_W-1:0] s
    );
        return (s == S_MAX) ? s : s + 1'b1;
    endfunction

    assign w_press_l = io_bus.L & ~r_prev_l;
    assign w_press_r = io_bus.R & ~r_prev_r;
    assign w_move_l  = w_press_l & ~w_press_r;
    assign w_move_r  = w_press_r & ~w_press_l;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state     <= S_PLAY;
            r_pos       <= P_CTR;
            r_hold      <= '0;
            r_prev_l    <= 1'b1;
            r_prev_r    <= 1'b1;
            r_lights    <= ONE << P_CTR;
            r_winner    <= 2'b00;
            r_score_l   <= '0;
            r_score_r   <= '0;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_pos       <= w_pos;
            r_hold      <= w_hold;
            r_prev_l    <= io_bus.L;
            r_prev_r    <= io_bus.R;
            r_lights    <= w_lights;
            r_winner    <= w_winner;
            r_score_l   <= w_score_l;
            r_score_r   <= w_score_r;
            r_game_over <= w_game_over;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_pos       = r_pos;
        w_hold      = r_hold;
        w_winner    = r_winner;
        w_score_l   = r_score_l;
        w_score_r   = r_score_r;
        w_game_over = r_game_over;
        w_lights    = '0;
        case (r_state)
            S_PLAY: begin
                if (w_move_l) begin
                    if (r_pos == P_MAX) begin
                        w_winner  = 2'b10;
                        w_score_l = sat_inc(r_score_l);
                        w_hold    = '0;
                        w_state   = (w_score_l == S_MAX) ? S_DONE : S_WIN;
                    end else begin
                        w_pos = r_pos + 1'b1;
                    end
                end else if (w_move_r) begin
                    if (r_pos == '0) begin
                        w_winner  = 2'b01;
                        w_score_r = sat_inc(r_score_r);
                        w_hold    = '0;
                        w_state   = (w_score_r == S_MAX) ? S_DONE : S_WIN;
                    end else begin
                        w_pos = r_pos - 1'b1;
                    end
                end
            end
            S_WIN: begin
                // Counter is cleared on entry, so checking the last
                // value here gives exactly HOLD_CYCLES cycles of display.
                if (r_hold == H_LAST) begin
                    w_state  = S_PLAY;
                    w_pos    = P_CTR;
                    w_winner = 2'b00;
                    w_hold   = '0;
                end else begin
                    w_hold = r_hold + 1'b1;
                end
            end
            S_DONE: begin
                w_state = S_DONE;
            end
            default: begin
                w_state  = S_PLAY;
                w_pos    = P_CTR;
                w_winner = 2'b00;
                w_hold   = '0;
            end
        endcase
        if (w_state == S_DONE)
            w_game_over = 1'b1;
        if (w_state == S_PLAY)
            w_lights = ONE << w_pos;
    end

    assign io_bus.lights    = r_lights;
    assign io_bus.winner    = r_winner;
    assign io_bus.score_l   = r_score_l;
    assign io_bus.score_r   = r_score_r;
    assign io_bus.game_over = r_game_over;
endmodule
